tnn_seq_classifier: RTL

TNN_SEQ_CLASSIFIER -- requirements
Module: tnn_seq_classifier

---
 rtl/tnn_pkg.sv | 24 ++
 rtl/tnn_argmax.sv | 29 ++
 rtl/tnn_seq_classifier.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/tnn_pkg.sv
// Shared definitions for the ternary neural-network sequential classifier:
// ternary weight codes, weight decode and controller state encoding.
package tnn_pkg;

    localparam logic [1:0] TERN_POS = 2'b01;
    localparam logic [1:0] TERN_NEG = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ARGMAX,
        DONE
    } tnn_state_e;

    // 2'b00 and 2'b10 both decode to zero.
    function automatic logic signed [1:0] tern_decode(input logic [1:0] code);
        case (code)
            TERN_POS: return 2'sb01;
            TERN_NEG: return 2'sb11;
            default:  return 2'sb00;
        endcase
    endfunction

endpackage

// File: rtl/tnn_argmax.sv
// Combinational argmax over CLASS_CNT packed signed scores; the lowest index
// wins on ties.
module tnn_argmax #(
    parameter int CLASS_CNT = 6,
    parameter int SW        = 7,
    parameter int IW        = $clog2(CLASS_CNT)
) (
    input  logic [CLASS_CNT*SW-1:0] scores_i,
    output logic [IW-1:0]           idx_o
);

    logic signed [SW-1:0] best;
    logic signed [SW-1:0] cur;

    always_comb begin
        best  = $signed(scores_i[SW-1:0]);
        cur   = '0;
        idx_o = '0;
        for (int unsigned c = 1; c < CLASS_CNT; c++) begin
            cur = $signed(scores_i[c*SW +: SW]);
            // Strict compare keeps the earlier index on equal scores.
            if (cur > best) begin
                best  = cur;
                idx_o = IW'(c);
            end
        end
    end

endmodule

// File: rtl/tnn_seq_classifier.sv
// Sequential ternary two-layer classifier: one hidden neuron per cycle, then
// argmax. Define TNN_SCORE_OUT_EN to expose the final class scores as a port.
module tnn_seq_classifier #(
    parameter int                                FEAT_CNT   = 11,
    parameter int                                HIDDEN_CNT = 40,
    parameter int                                FEAT_BITS  = 4,
    parameter int                                CLASS_CNT  = 6,
    parameter logic [HIDDEN_CNT*FEAT_CNT*2-1:0]  W1         = '0,
    parameter logic [CLASS_CNT*HIDDEN_CNT*2-1:0] W2         = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [FEAT_CNT*FEAT_BITS-1:0] features,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(CLASS_CNT)-1:0]  prediction
`ifdef TNN_SCORE_OUT_EN
    ,
    output logic [CLASS_CNT*($clog2(HIDDEN_CNT+1)+1)-1:0] scores
`endif
);

    import tnn_pkg::*;

    localparam int SUMW = FEAT_BITS + $clog2(FEAT_CNT) + 2;
    localparam int SW   = $clog2(HIDDEN_CNT + 1) + 1;
    localparam int CW   = $clog2(HIDDEN_CNT + 1);
    localparam int IW   = $clog2(CLASS_CNT);
    localparam logic [CW-1:0] H_END = CW'(HIDDEN_CNT);

    tnn_state_e                    state_q;
    logic [FEAT_CNT*FEAT_BITS-1:0] feat_q;
    logic [CW-1:0]                 cnt_q;
    logic [CW-1:0]                 hidx_q;
    logic                          h_q;
    logic                          hv_q;
    logic                          in_ready_q;
    logic                          out_valid_q;
    logic [IW-1:0]                 pred_q;
    logic signed [SW-1:0]          score_q [CLASS_CNT];

    logic signed [SW-1:0]          score_d [CLASS_CNT];
    logic signed [SUMW-1:0]        sum_d;
    logic                          h_d;
    logic [CLASS_CNT*SW-1:0]       score_flat;
    logic [IW-1:0]                 best_idx;

    // Hidden layer: signed ternary dot product for the neuron under the counter.
    always_comb begin
        int unsigned          nidx;
        logic signed [1:0]    w;
        logic signed [SUMW-1:0] fx;
        sum_d = '0;
        w     = '0;
        fx    = '0;
        nidx  = (cnt_q < H_END) ? int'(cnt_q) : 0;
        for (int unsigned i = 0; i < FEAT_CNT; i++) begin
            w  = tern_decode(W1[(nidx*FEAT_CNT + i)*2 +: 2]);
            fx = $signed({{(SUMW-FEAT_BITS){1'b0}}, feat_q[i*FEAT_BITS +: FEAT_BITS]});
            case (w)
                2'sb01:  sum_d = sum_d + fx;
                2'sb11:  sum_d = sum_d - fx;
                default: sum_d = sum_d;
            endcase
        end
        h_d = ~sum_d[SUMW-1];
    end

    // Output layer: accumulate the registered activation of neuron hidx_q.
    always_comb begin
        logic signed [1:0] w2;
        logic signed [1:0] term;
        w2   = '0;
        term = '0;
        for (int unsigned c = 0; c < CLASS_CNT; c++) begin
            w2         = tern_decode(W2[(c*HIDDEN_CNT + int'(hidx_q))*2 +: 2]);
            term       = h_q ? w2 : -w2;
            score_d[c] = score_q[c] + $signed({{(SW-2){term[1]}}, term});
            score_flat[c*SW +: SW] = score_q[c];
        end
    end

    tnn_argmax #(
        .CLASS_CNT(CLASS_CNT),
        .SW       (SW),
        .IW       (IW)
    ) u_argmax (
        .scores_i(score_flat),
        .idx_o   (best_idx)
    );

    // The activation is registered before accumulation, so RUN spends one
    // extra drain cycle (cnt_q == HIDDEN_CNT) folding in the last neuron.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            feat_q      <= '0;
            cnt_q       <= '0;
            hidx_q      <= '0;
            h_q         <= 1'b0;
            hv_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            pred_q      <= '0;
            for (int unsigned c = 0; c < CLASS_CNT; c++) begin
                score_q[c] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        feat_q     <= features;
                        cnt_q      <= '0;
                        hv_q       <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                        for (int unsigned c = 0; c < CLASS_CNT; c++) begin
                            score_q[c] <= '0;
                        end
                    end
                end
                RUN: begin
                    if (cnt_q != H_END) begin
                        h_q    <= h_d;
                        hidx_q <= cnt_q;
                        hv_q   <= 1'b1;
                        cnt_q  <= cnt_q + CW'(1);
                    end else begin
                        hv_q    <= 1'b0;
                        state_q <= ARGMAX;
                    end
                    if (hv_q) begin
                        for (int unsigned c = 0; c < CLASS_CNT; c++) begin
                            score_q[c] <= score_d[c];
                        end
                    end
                end
                ARGMAX: begin
                    pred_q      <= best_idx;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign prediction = pred_q;

`ifdef TNN_SCORE_OUT_EN
    assign scores = score_flat;
`endif

endmodule
